// File: rtl/hazard_unit.sv
// Hazard unit for an in-order pipeline.
// Tracks destination info for DEPTH in-flight stages after decode, selects
// forwarded operands for the decode-stage sources, raises a load-use stall
// and a branch flush, and keeps saturating stall/flush event counters.
module hazard_unit #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int DEPTH      = 3,
  parameter int BR_STAGE   = 1,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  dec_valid,
  input  logic [RA_W-1:0]       dec_rs1,
  input  logic [RA_W-1:0]       dec_rs2,
  input  logic                  dec_use1,
  input  logic                  dec_use2,
  input  logic [RA_W-1:0]       dec_rd,
  input  logic                  dec_wen,
  input  logic                  dec_ld,
  input  logic                  br_taken,
  input  logic [XLEN-1:0]       rf_data1,
  input  logic [XLEN-1:0]       rf_data2,
  input  logic [DEPTH*XLEN-1:0] stg_data,
  output logic [XLEN-1:0]       opnd1,
  output logic [XLEN-1:0]       opnd2,
  output logic [SEL_W-1:0]      fwd_sel1,
  output logic [SEL_W-1:0]      fwd_sel2,
  output logic                  stall,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Tracked entries: index 0 is EX, DEPTH-1 is WB.
  logic [DEPTH-1:0]           v_q, v_d;
  logic [DEPTH-1:0]           wen_q, wen_d;
  logic [DEPTH-1:0]           ld_q, ld_d;
  logic [DEPTH-1:0][RA_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]           flush_cnt_q, flush_cnt_d;

  logic hz1, hz2;
  logic accept;

  // An entry produces a usable result for source r; x0 never matches.
  function automatic logic entry_match(input int idx, input logic [RA_W-1:0] r);
    return v_q[idx] && wen_q[idx] && (rd_q[idx] == r) && (r != '0);
  endfunction

  // Forwarding select and operand mux for both sources, plus load-use flags.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    opnd1    = rf_data1;
    opnd2    = rf_data2;
    hz1      = 1'b0;
    hz2      = 1'b0;
    // NOTE: the scan runs oldest to youngest so the last hit, the lowest
    // index, is the one that sticks; the youngest producer must win.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (dec_use1 && entry_match(i, dec_rs1)) begin
        fwd_sel1 = SEL_W'(i + 1);
        opnd1    = stg_data[i*XLEN +: XLEN];
        hz1      = ld_q[i] && (i < LOAD_STAGE);
      end
      if (dec_use2 && entry_match(i, dec_rs2)) begin
        fwd_sel2 = SEL_W'(i + 1);
        opnd2    = stg_data[i*XLEN +: XLEN];
        hz2      = ld_q[i] && (i < LOAD_STAGE);
      end
    end
  end

  // A redirect kills the waiting instruction anyway, so flush masks the stall.
  assign flush  = br_taken;
  assign stall  = dec_valid && (hz1 || hz2) && !br_taken;
  assign accept = dec_valid && !stall && !flush;

  // Next state: insert at EX (or a bubble), shift the rest, kill young entries on flush.
  always_comb begin
    v_d   = '0;
    wen_d = '0;
    ld_d  = '0;
    rd_d  = '0;
    if (accept) begin
      v_d[0]   = 1'b1;
      wen_d[0] = dec_wen;
      ld_d[0]  = dec_ld;
      rd_d[0]  = dec_rd;
    end
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]   = v_q[i-1] && !(flush && (i <= BR_STAGE));
      wen_d[i] = wen_q[i-1];
      ld_d[i]  = ld_q[i-1];
      rd_d[i]  = rd_q[i-1];
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers with synchronous reset that drops all in-flight tracking.
  always_ff @(posedge CLK) begin
    // NOTE: every field of every entry is cleared, not only v, so the
    // tracked state after reset is fully defined rather than stale.
    if (RST) begin
      v_q         <= '0;
      wen_q       <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      wen_q       <= wen_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by a
// randomized run, all compared against a queue-based instruction model.
module tb_hazard_unit;

  localparam int XLEN       = 32;
  localparam int RA_W       = 5;
  localparam int DEPTH      = 3;
  localparam int BR_STAGE   = 1;
  localparam int LOAD_STAGE = 1;
  localparam int CNT_W      = 4;
  localparam int SEL_W      = $clog2(DEPTH + 1);
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                  CLK, RST;
  logic                  dec_valid, dec_use1, dec_use2, dec_wen, dec_ld, br_taken;
  logic [RA_W-1:0]       dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]       rf_data1, rf_data2, opnd1, opnd2;
  logic [DEPTH*XLEN-1:0] stg_data;
  logic [SEL_W-1:0]      fwd_sel1, fwd_sel2;
  logic                  stall, flush;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;
  logic [XLEN-1:0]       stg [DEPTH];

  hazard_unit #(
    .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .BR_STAGE(BR_STAGE),
    .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .dec_valid(dec_valid), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_rd(dec_rd), .dec_wen(dec_wen), .dec_ld(dec_ld), .br_taken(br_taken),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .stg_data(stg_data),
    .opnd1(opnd1), .opnd2(opnd2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    stg_data = '0;
    for (int i = 0; i < DEPTH; i++) stg_data[i*XLEN +: XLEN] = stg[i];
  end

  // Reference model: in-flight instructions, youngest at the front.
  typedef struct {
    bit            v;
    bit [RA_W-1:0] rd;
    bit            wen;
    bit            ld;
  } instr_t;

  instr_t pipe[$];
  int     m_scnt, m_fcnt;
  int     errors, checks;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Youngest in-flight producer of r, as a 1-based position; 0 means register file.
  function automatic int ref_sel(input bit [RA_W-1:0] r, input bit use_it);
    if (!use_it || r == 0) return 0;
    foreach (pipe[k]) if (pipe[k].v && pipe[k].wen && pipe[k].rd == r) return k + 1;
    return 0;
  endfunction

  function automatic bit load_not_ready(input int s);
    return (s != 0) && pipe[s-1].ld && ((s - 1) < LOAD_STAGE);
  endfunction

  task automatic model_clear();
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back('{0, 0, 0, 0});
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  task automatic drive(input bit v, input bit [RA_W-1:0] rs1, input bit [RA_W-1:0] rs2,
                       input bit u1, input bit u2, input bit [RA_W-1:0] rd,
                       input bit wen, input bit ld, input bit br);
    dec_valid = v;   dec_rs1 = rs1; dec_rs2 = rs2; dec_use1 = u1; dec_use2 = u2;
    dec_rd    = rd;  dec_wen = wen; dec_ld  = ld;  br_taken = br;
    rf_data1  = $urandom; rf_data2 = $urandom;
    for (int i = 0; i < DEPTH; i++) stg[i] = $urandom;
  endtask

  // One clock: check combinational outputs, take the edge, update model, check counters.
  task automatic cycle();
    int s1, s2;
    bit exp_stall, acc;
    logic [XLEN-1:0] e1, e2;
    instr_t ne;
    #1;
    s1 = ref_sel(dec_rs1, dec_use1);
    s2 = ref_sel(dec_rs2, dec_use2);
    e1 = (s1 == 0) ? rf_data1 : stg[s1-1];
    e2 = (s2 == 0) ? rf_data2 : stg[s2-1];
    exp_stall = dec_valid && !br_taken && (load_not_ready(s1) || load_not_ready(s2));
    check("fwd_sel1", fwd_sel1, s1);
    check("fwd_sel2", fwd_sel2, s2);
    check("opnd1", opnd1, e1);
    check("opnd2", opnd2, e2);
    check("stall", stall, exp_stall);
    check("flush", flush, br_taken);
    @(posedge CLK);
    if (RST) begin
      model_clear();
    end else begin
      acc = dec_valid && !exp_stall && !br_taken;
      if (exp_stall && m_scnt < CNT_MAX) m_scnt++;
      if (br_taken && m_fcnt < CNT_MAX) m_fcnt++;
      ne = acc ? '{1, dec_rd, dec_wen, dec_ld} : '{0, 0, 0, 0};
      pipe.push_front(ne);
      void'(pipe.pop_back());
      if (br_taken) for (int k = 0; k <= BR_STAGE; k++) pipe[k].v = 0;
    end
    #1;
    check("stall_cnt", stall_cnt, m_scnt);
    check("flush_cnt", flush_cnt, m_fcnt);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    model_clear();
    #1;
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RST = 1'b1;
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    do_reset();

    // Reset state: nothing forwarded, flush follows br_taken.
    drive(1, 5, 6, 1, 1, 4, 1, 0, 1);
    #1;
    check("rst_sel1", fwd_sel1, 0);
    check("rst_sel2", fwd_sel2, 0);
    check("rst_opnd1", opnd1, rf_data1);
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 1);
    cycle();

    // Back-to-back dependency on x5.
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cycle();
    drive(1, 5, 0, 1, 0, 9, 1, 0, 0);
    stg[0] = 32'h1234_5678;
    #1;
    check("b2b_sel1", fwd_sel1, 1);
    check("b2b_opnd1", opnd1, 32'h1234_5678);
    check("b2b_stall", stall, 0);
    cycle();

    // Load-use on x7: one stall, then forward from entry 1.
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    cycle();
    drive(1, 0, 7, 0, 1, 8, 1, 0, 0);
    #1;
    check("lu_stall", stall, 1);
    cycle();
    drive(1, 0, 7, 0, 1, 8, 1, 0, 0);
    #1;
    check("lu_stall_after", stall, 0);
    check("lu_sel2", fwd_sel2, 2);
    check("lu_opnd2", opnd2, stg[1]);
    check("lu_stall_cnt", stall_cnt, 1);
    cycle();

    // Youngest wins: x3 at entries 0 and 2.
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0); cycle();
    drive(1, 3, 0, 1, 0, 4, 0, 0, 0);
    #1;
    check("young_sel1", fwd_sel1, 1);
    cycle();

    // x0 write never forwards.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
    drive(1, 0, 0, 1, 0, 4, 1, 0, 0);
    #1;
    check("x0_sel1", fwd_sel1, 0);
    check("x0_opnd1", opnd1, rf_data1);
    cycle();

    // Flush during a load-use stall.
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0); cycle();
    drive(1, 0, 7, 0, 1, 8, 1, 0, 1);
    #1;
    check("fl_stall", stall, 0);
    check("fl_flush", flush, 1);
    cycle();
    drive(1, 0, 7, 0, 1, 8, 1, 0, 0);
    #1;
    check("fl_killed_sel2", fwd_sel2, 0);
    check("fl_flush_cnt", flush_cnt, 1);
    check("fl_stall_cnt", stall_cnt, 0);
    cycle();

    // Saturation: dependent loads alternate stall/accept, giving 20 stalls.
    do_reset();
    repeat (41) begin
      drive(1, 0, 7, 0, 1, 7, 1, 1, 0);
      cycle();
    end
    check("sat_stall_cnt", stall_cnt, 15);
    RST = 1'b1;
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cycle();
    RST = 1'b0;
    check("sat_rst_cnt", stall_cnt, 0);
    drive(1, 5, 0, 1, 0, 6, 1, 0, 0);
    #1;
    check("rst_cycle_not_inserted", fwd_sel1, 0);
    cycle();

    // Randomized traffic with occasional mid-run resets.
    repeat (1500) begin
      RST = ($urandom_range(99) == 0);
      drive($urandom_range(9) != 0, RA_W'($urandom_range(3)), RA_W'($urandom_range(3)),
            $urandom_range(1), $urandom_range(1), RA_W'($urandom_range(3)),
            $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(9) == 0);
      cycle();
    end
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 Parameter DEPTH, default 3, number of tracked in-flight stages after decode (index 0 = EX, DEPTH-1 = WB).
REQ-004 Parameter BR_STAGE, default 1, index of the stage that presents br_taken (1 = ME); range 1..DEPTH-1.
REQ-005 Parameter LOAD_STAGE, default 2, lowest index at which a load's data is valid on stg_data; range 1..DEPTH-1.
REQ-006 Parameter CNT_W, default 16, width of the performance counters.
REQ-007 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-008 RST  in  1  reset, synchronous, active-high.
REQ-009 dec_valid  in  1  the decode-stage instruction is valid.
REQ-010 dec_rs1, dec_rs2  in  RA_W each  decode source register addresses.
REQ-011 dec_use1, dec_use2  in  1 each  the instruction reads rs1 or rs2.
REQ-012 dec_rd  in  RA_W  decode destination register.
REQ-013 dec_wen, dec_ld  in  1 each  the instruction writes rd; the instruction is a load.
REQ-014 br_taken  in  1  the instruction at index BR_STAGE redirects the PC this cycle.
REQ-015 rf_data1, rf_data2  in  XLEN each  register-file read data.
REQ-016 stg_data  in  DEPTH*XLEN  result of tracked entry i on bits [i*XLEN +: XLEN].
REQ-017 opnd1, opnd2  out  XLEN each  forwarded operands.
REQ-018 fwd_sel1, fwd_sel2  out  clog2(DEPTH+1) each  0 = register file; k = entry k-1.
REQ-019 stall  out  1  hold fetch and decode, and insert a bubble at EX.
REQ-020 flush  out  1  kill fetch, decode and every entry with index < BR_STAGE.
REQ-021 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-022 Each tracked entry SHALL hold {v, rd, wen, ld}; an entry "matches" source r when v && wen && rd == r && r != 0.
REQ-023 fwd_selN SHALL equal k+1, where k is the lowest matching index for dec_rsN with dec_useN=1; otherwise fwd_selN SHALL be 0.
REQ-024 opndN SHALL be rf_dataN when fwd_selN = 0, else stg_data entry fwd_selN-1; all outputs in REQ-023..REQ-027 are combinational from current state and inputs.
REQ-025 Load-use: stall SHALL be 1 when dec_valid and either source's selected entry k has ld=1 and k < LOAD_STAGE.
REQ-026 flush SHALL equal br_taken.
REQ-027 When flush=1, stall SHALL be 0; flush wins.
REQ-028 On each edge, entry 0 SHALL load {dec_valid, dec_rd, dec_wen, dec_ld} when dec_valid && !stall && !flush; otherwise it SHALL load a bubble (v=0).
REQ-029 On each edge, entry i (i >= 1) SHALL load entry i-1, forced to v=0 when flush && i <= BR_STAGE.
REQ-030 The entry at DEPTH-1 SHALL be discarded on the next edge, with no hold; the pipeline never stalls past decode.
REQ-031 stall_cnt SHALL increment on each edge where stall=1, and flush_cnt on each edge where flush=1; both saturate at all ones with no wrap.
REQ-032 dec_rd = 0 SHALL never create a match, even with dec_wen=1.

Reset
REQ-033 When RST=1 at an edge, every entry SHALL clear (v=0, rd=0, wen=0, ld=0) and both counters SHALL clear to 0; RST overrides any simultaneous stall or flush.
REQ-034 With all entries cleared, outputs SHALL be fwd_sel1 = fwd_sel2 = 0, opndN = rf_dataN, stall=0, and flush = br_taken.
REQ-035 Asserting RST mid-operation SHALL drop all in-flight tracking; an instruction presented in the reset cycle is not inserted.

Verification
REQ-036 Back-to-back dependency: add x5 accepted, then decode reads rs1=x5 with stg_data[0]=0x12345678 -> fwd_sel1=1, opnd1=0x12345678, stall=0.
REQ-037 Load-use: lw x7 sits at entry 0, decode reads rs2=x7 -> stall=1 for exactly one cycle, then fwd_sel2=2 and stall_cnt=1.
REQ-038 Youngest wins: x3 is written by entries 0 and 2, decode reads x3 -> fwd_sel1=1.
REQ-039 x0 write: entry 0 has rd=0 with wen=1, decode reads x0 -> fwd_sel1=0, opnd1=rf_data1.
REQ-040 Flush during stall: load-use stall with br_taken=1 in the same cycle -> stall=0, flush=1, entries 0..BR_STAGE become v=0 next cycle, flush_cnt=1, stall_cnt unchanged.
REQ-041 Saturation with CNT_W=4: hold a load-use stall for 20 cycles -> stall_cnt stops at 15; RST then clears it to 0.
